// File: rtl/dat_xfer_sequencer_if.sv
// Handshake bundle between the DAT transfer sequencer, the register block
// and the DAT datapath / command path.
//   slave  : sequencer side (mode/launch/datapath status in, control out)
//   master : register block + datapath side (the reverse directions)
interface dat_xfer_sequencer_if #(
  parameter int unsigned BLK_CNT_W = 16,
  parameter int unsigned TMO_W     = 16
) ();
  logic                 start;
  logic                 sw_reset;
  logic                 dir;
  logic                 multi_blk;
  logic                 blk_cnt_en;
  logic                 auto_cmd12;
  logic [BLK_CNT_W-1:0] blk_cnt;
  logic [TMO_W-1:0]     tmo_limit;
  logic                 fifo_ready;
  logic                 blk_done;
  logic                 crc_err;
  logic                 dat_busy;
  logic                 cmd12_ack;
  logic                 enable_trans;
  logic                 blk_dir;
  logic                 active;
  logic                 cmd12_req;
  logic                 xfer_complete;
  logic                 crc_err_irq;
  logic                 tmo_err_irq;
  logic [BLK_CNT_W-1:0] blocks_left;

  modport slave (
    input  start, sw_reset, dir, multi_blk, blk_cnt_en, auto_cmd12, blk_cnt,
           tmo_limit, fifo_ready, blk_done, crc_err, dat_busy, cmd12_ack,
    output enable_trans, blk_dir, active, cmd12_req, xfer_complete,
           crc_err_irq, tmo_err_irq, blocks_left
  );

  modport master (
    output start, sw_reset, dir, multi_blk, blk_cnt_en, auto_cmd12, blk_cnt,
           tmo_limit, fifo_ready, blk_done, crc_err, dat_busy, cmd12_ack,
    input  enable_trans, blk_dir, active, cmd12_req, xfer_complete,
           crc_err_irq, tmo_err_irq, blocks_left
  );
endinterface

// File: rtl/dat_xfer_sequencer.sv
// SD host DAT transfer sequencer: turns a data-command launch into a series
// of per-block transfers, gating enable_trans per block, waiting on FIFO
// readiness and card busy, counting blocks, requesting auto-CMD12 and
// reporting completion / CRC / timeout events.
// Ports:
//   clk      - single clock, posedge
//   reset_n  - asynchronous active-low reset
//   bus      - slave side of dat_xfer_sequencer_if (mode, launch, datapath
//              status in; enable_trans, status, pulses, blocks_left out)
module dat_xfer_sequencer #(
  parameter int unsigned BLK_CNT_W = 16,
  parameter int unsigned TMO_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  dat_xfer_sequencer_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE, FIFO_WAIT, XFER, BUSY_WAIT, NEXT, CMD12, DONE
  } state_t;

  localparam logic [BLK_CNT_W-1:0] BLK_ONE = BLK_CNT_W'(1);

  state_t               state_q, state_d;
  logic                 dir_q, dir_d;
  logic                 multi_q, multi_d;
  logic                 cnt_en_q, cnt_en_d;
  logic                 auto_q, auto_d;
  logic                 abort_q, abort_d;
  logic [BLK_CNT_W-1:0] blocks_left_q, blocks_left_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 crc_irq_q, crc_irq_d;
  logic                 tmo_irq_q, tmo_irq_d;

  logic tmo_hit;
  logic use_cmd12;
  logic infinite;

  assign tmo_hit   = (bus.tmo_limit != '0) && (tmo_cnt_q == bus.tmo_limit);
  assign use_cmd12 = multi_q && auto_q;
  assign infinite  = multi_q && !cnt_en_q;

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    multi_d       = multi_q;
    cnt_en_d      = cnt_en_q;
    auto_d        = auto_q;
    abort_d       = abort_q;
    blocks_left_d = blocks_left_q;
    tmo_cnt_d     = '0;          // cleared everywhere except while timing
    crc_irq_d     = 1'b0;
    tmo_irq_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dir_d    = bus.dir;
          multi_d  = bus.multi_blk;
          cnt_en_d = bus.blk_cnt_en;
          auto_d   = bus.auto_cmd12;
          abort_d  = 1'b0;
          if (bus.multi_blk && bus.blk_cnt_en) begin
            blocks_left_d = bus.blk_cnt;
          end else if (!bus.multi_blk) begin
            blocks_left_d = BLK_ONE;
          end
          if (bus.multi_blk && bus.blk_cnt_en && (bus.blk_cnt == '0)) begin
            state_d = DONE;
          end else begin
            state_d = FIFO_WAIT;
          end
        end
      end
      FIFO_WAIT: begin
        if (bus.fifo_ready) state_d = XFER;
      end
      XFER: begin
        // timeout wins over a coincident blk_done
        if (tmo_hit) begin
          tmo_irq_d = 1'b1;
          state_d   = IDLE;
        end else if (bus.blk_done) begin
          if (bus.crc_err) begin
            crc_irq_d = 1'b1;
            abort_d   = 1'b1;
            state_d   = use_cmd12 ? CMD12 : IDLE;
          end else begin
            state_d   = dir_q ? NEXT : BUSY_WAIT;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      BUSY_WAIT: begin
        if (tmo_hit) begin
          tmo_irq_d = 1'b1;
          state_d   = IDLE;
        end else if (!bus.dat_busy) begin
          state_d   = NEXT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      NEXT: begin
        if (infinite) begin
          state_d = FIFO_WAIT;
        end else begin
          blocks_left_d = blocks_left_q - BLK_ONE;
          if (blocks_left_q == BLK_ONE) begin
            state_d = use_cmd12 ? CMD12 : DONE;
          end else begin
            state_d = FIFO_WAIT;
          end
        end
      end
      CMD12: begin
        if (bus.cmd12_ack) state_d = abort_q ? IDLE : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.sw_reset) begin
      state_d       = IDLE;
      dir_d         = 1'b0;
      multi_d       = 1'b0;
      cnt_en_d      = 1'b0;
      auto_d        = 1'b0;
      abort_d       = 1'b0;
      blocks_left_d = '0;
      tmo_cnt_d     = '0;
      crc_irq_d     = 1'b0;
      tmo_irq_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      dir_q         <= 1'b0;
      multi_q       <= 1'b0;
      cnt_en_q      <= 1'b0;
      auto_q        <= 1'b0;
      abort_q       <= 1'b0;
      blocks_left_q <= '0;
      tmo_cnt_q     <= '0;
      crc_irq_q     <= 1'b0;
      tmo_irq_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      multi_q       <= multi_d;
      cnt_en_q      <= cnt_en_d;
      auto_q        <= auto_d;
      abort_q       <= abort_d;
      blocks_left_q <= blocks_left_d;
      tmo_cnt_q     <= tmo_cnt_d;
      crc_irq_q     <= crc_irq_d;
      tmo_irq_q     <= tmo_irq_d;
    end
  end

  assign bus.enable_trans  = (state_q == XFER);
  assign bus.active        = (state_q != IDLE);
  assign bus.cmd12_req     = (state_q == CMD12);
  assign bus.xfer_complete = (state_q == DONE);
  assign bus.blk_dir       = dir_q;
  assign bus.crc_err_irq   = crc_irq_q;
  assign bus.tmo_err_irq   = tmo_irq_q;
  assign bus.blocks_left   = blocks_left_q;

endmodule

// File: tb/tb_dat_xfer_sequencer.sv
module tb_dat_xfer_sequencer;

  logic clk;
  logic reset_n;

  dat_xfer_sequencer_if #(.BLK_CNT_W(16), .TMO_W(16)) bus ();

  dat_xfer_sequencer #(.BLK_CNT_W(16), .TMO_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // cumulative event counters, observed mid-cycle
  int  n_win = 0, n_cmp = 0, n_crc = 0, n_tmo = 0, n_c12 = 0;
  bit  en_prev = 0, c12_prev = 0;
  always @(negedge clk) begin
    if (bus.enable_trans && !en_prev) n_win++;
    if (bus.cmd12_req && !c12_prev) n_c12++;
    if (bus.xfer_complete) n_cmp++;
    if (bus.crc_err_irq) n_crc++;
    if (bus.tmo_err_irq) n_tmo++;
    en_prev  = bus.enable_trans;
    c12_prev = bus.cmd12_req;
  end

  // reference: block count the register block should currently show
  int model_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.enable_trans) begin ok = 1; break; end
      step();
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.active) begin ok = 1; break; end
      step();
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_c12(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.cmd12_req) begin ok = 1; break; end
      step();
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic launch(input bit d, input bit m, input bit ce, input bit a12, input int cnt);
    bus.dir        = d;
    bus.multi_blk  = m;
    bus.blk_cnt_en = ce;
    bus.auto_cmd12 = a12;
    bus.blk_cnt    = 16'(cnt);
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
    chk("active_after_start", {31'd0, bus.active}, 32'd1);
  endtask

  // One whole transfer. crc_at = index of block that fails CRC (>= block
  // count means none). Expectations come from block arithmetic only.
  task automatic run_xfer(input bit d, input bit m, input bit ce, input bit a12,
                          input int cnt, input int crc_at, input int dly, input int busy);
    bit inf, abort, exp_c12;
    int nblk, good, served, start_left, exp_left;
    int w0, c0, r0, t0, k0;
    inf        = m && !ce;
    nblk       = inf ? crc_at + 1 : (m ? cnt : 1);
    abort      = crc_at < nblk;
    good       = abort ? crc_at : nblk;
    served     = good + (abort ? 1 : 0);
    start_left = inf ? model_left : (m ? cnt : 1);
    exp_left   = inf ? model_left : start_left - good;
    exp_c12    = m && a12 && (served > 0);
    w0 = n_win; c0 = n_cmp; r0 = n_crc; t0 = n_tmo; k0 = n_c12;
    bus.fifo_ready = 1'b1;
    launch(d, m, ce, a12, cnt);
    for (int i = 0; i < served; i++) begin
      wait_en("wait_enable");
      chk("blocks_left_in_window", 32'(bus.blocks_left), 32'(inf ? model_left : start_left - i));
      repeat (dly) step();
      bus.blk_done = 1'b1;
      bus.crc_err  = (i == crc_at);
      if (!d && i != crc_at) bus.dat_busy = 1'b1;
      step();
      bus.blk_done = 1'b0;
      bus.crc_err  = 1'b0;
      chk("enable_low_after_blk_done", {31'd0, bus.enable_trans}, 32'd0);
      if (bus.dat_busy) begin
        repeat (busy) step();
        bus.dat_busy = 1'b0;
      end
    end
    if (exp_c12) begin
      wait_c12("wait_cmd12_req");
      repeat ($urandom_range(0, 3)) step();
      bus.cmd12_ack = 1'b1;
      step();
      bus.cmd12_ack = 1'b0;
      chk("cmd12_req_drop_after_ack", {31'd0, bus.cmd12_req}, 32'd0);
      chk("complete_after_ack", {31'd0, bus.xfer_complete}, {31'd0, !abort});
    end
    wait_idle("wait_idle");
    step();
    chk("enable_windows", 32'(n_win - w0), 32'(served));
    chk("xfer_complete_count", 32'(n_cmp - c0), abort ? 32'd0 : 32'd1);
    chk("crc_irq_count", 32'(n_crc - r0), abort ? 32'd1 : 32'd0);
    chk("tmo_irq_count", 32'(n_tmo - t0), 32'd0);
    chk("cmd12_count", 32'(n_c12 - k0), exp_c12 ? 32'd1 : 32'd0);
    chk("blocks_left_final", 32'(bus.blocks_left), 32'(exp_left));
    model_left = exp_left;
  endtask

  initial begin
    int w0, c0, t0, k0, n, nblk, cnt, crc_at;
    bit en_seen, tmo_seen, m;

    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.sw_reset   = 1'b0;
    bus.dir        = 1'b0;
    bus.multi_blk  = 1'b0;
    bus.blk_cnt_en = 1'b0;
    bus.auto_cmd12 = 1'b0;
    bus.blk_cnt    = '0;
    bus.tmo_limit  = '0;
    bus.fifo_ready = 1'b0;
    bus.blk_done   = 1'b0;
    bus.crc_err    = 1'b0;
    bus.dat_busy   = 1'b0;
    bus.cmd12_ack  = 1'b0;
    repeat (3) step();
    chk("rst_active", {31'd0, bus.active}, 32'd0);
    chk("rst_enable", {31'd0, bus.enable_trans}, 32'd0);
    chk("rst_outputs", {25'd0, bus.blk_dir, bus.cmd12_req, bus.xfer_complete,
                        bus.crc_err_irq, bus.tmo_err_irq, 2'd0}, 32'd0);
    chk("rst_blocks_left", 32'(bus.blocks_left), 32'd0);
    reset_n = 1'b1;
    step();
    model_left = 0;

    // single-block read, exact latencies
    w0 = n_win; k0 = n_c12;
    bus.fifo_ready = 1'b1;
    launch(1'b1, 1'b0, 1'b0, 1'b0, 0);
    wait_en("sb_wait_enable");
    chk("sb_blk_dir", {31'd0, bus.blk_dir}, 32'd1);
    chk("sb_blocks_left", 32'(bus.blocks_left), 32'd1);
    repeat (10) step();
    bus.blk_done = 1'b1;
    step();
    bus.blk_done = 1'b0;
    chk("sb_enable_K1", {31'd0, bus.enable_trans}, 32'd0);
    chk("sb_complete_K1", {31'd0, bus.xfer_complete}, 32'd0);
    step();
    chk("sb_complete_K2", {31'd0, bus.xfer_complete}, 32'd1);
    step();
    chk("sb_active_K3", {31'd0, bus.active}, 32'd0);
    chk("sb_complete_K3", {31'd0, bus.xfer_complete}, 32'd0);
    chk("sb_windows", 32'(n_win - w0), 32'd1);
    chk("sb_no_cmd12", 32'(n_c12 - k0), 32'd0);
    chk("sb_blocks_left_end", 32'(bus.blocks_left), 32'd0);

    // multi-block write, 3 blocks, auto CMD12, 5 busy cycles per block
    run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 3, 99, 4, 5);

    // fifo not ready before block 2 of 2; FIFO_WAIT must not time out
    bus.tmo_limit = 16'd8;
    w0 = n_win; c0 = n_cmp; t0 = n_tmo;
    bus.fifo_ready = 1'b1;
    launch(1'b1, 1'b1, 1'b1, 1'b0, 2);
    wait_en("fw_wait_enable1");
    repeat (3) step();
    bus.blk_done   = 1'b1;
    bus.fifo_ready = 1'b0;
    step();
    bus.blk_done   = 1'b0;
    en_seen  = 1'b0;
    tmo_seen = 1'b0;
    repeat (20) begin
      step();
      en_seen  |= bus.enable_trans;
      tmo_seen |= bus.tmo_err_irq;
    end
    chk("fw_enable_held_low", {31'd0, en_seen}, 32'd0);
    chk("fw_still_active", {31'd0, bus.active}, 32'd1);
    chk("fw_blocks_left", 32'(bus.blocks_left), 32'd1);
    bus.fifo_ready = 1'b1;
    wait_en("fw_wait_enable2");
    repeat (3) step();
    bus.blk_done = 1'b1;
    step();
    bus.blk_done = 1'b0;
    wait_idle("fw_wait_idle");
    step();
    chk("fw_no_timeout", {31'd0, tmo_seen}, 32'd0);
    chk("fw_tmo_count", 32'(n_tmo - t0), 32'd0);
    chk("fw_windows", 32'(n_win - w0), 32'd2);
    chk("fw_complete", 32'(n_cmp - c0), 32'd1);
    bus.tmo_limit = '0;
    model_left = 0;

    // CRC failure on block 2 of 4 with auto CMD12
    run_xfer(1'b1, 1'b1, 1'b1, 1'b1, 4, 1, 2, 0);

    // infinite mode: count untouched, ends on CRC error
    run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 0, 3, 1, 0);

    // data timeout, no blk_done
    bus.tmo_limit = 16'd16;
    c0 = n_cmp; t0 = n_tmo;
    launch(1'b1, 1'b0, 1'b0, 1'b0, 0);
    wait_en("tmo_wait_enable");
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (bus.tmo_err_irq) begin n = i; break; end
    end
    chk("tmo_latency", 32'(n), 32'd17);
    chk("tmo_enable", {31'd0, bus.enable_trans}, 32'd0);
    chk("tmo_active", {31'd0, bus.active}, 32'd0);
    step();
    chk("tmo_pulse_width", {31'd0, bus.tmo_err_irq}, 32'd0);
    chk("tmo_count", 32'(n_tmo - t0), 32'd1);
    chk("tmo_no_complete", 32'(n_cmp - c0), 32'd0);
    bus.tmo_limit = '0;
    model_left = 1;

    // sw_reset during BUSY_WAIT
    c0 = n_cmp;
    launch(1'b0, 1'b1, 1'b1, 1'b1, 3);
    wait_en("swr_wait_enable");
    step();
    bus.blk_done = 1'b1;
    bus.dat_busy = 1'b1;
    step();
    bus.blk_done = 1'b0;
    repeat (3) step();
    chk("swr_busy_active", {31'd0, bus.active}, 32'd1);
    bus.sw_reset = 1'b1;
    step();
    bus.sw_reset = 1'b0;
    chk("swr_active", {31'd0, bus.active}, 32'd0);
    chk("swr_outputs", {26'd0, bus.enable_trans, bus.blk_dir, bus.cmd12_req,
                        bus.xfer_complete, bus.crc_err_irq, bus.tmo_err_irq}, 32'd0);
    chk("swr_blocks_left", 32'(bus.blocks_left), 32'd0);
    bus.dat_busy = 1'b0;
    repeat (3) step();
    chk("swr_stays_idle", {31'd0, bus.active}, 32'd0);
    chk("swr_no_complete", 32'(n_cmp - c0), 32'd0);
    model_left = 0;

    // zero effective count: straight to DONE, no block, no CMD12
    launch(1'b1, 1'b1, 1'b1, 1'b1, 0);
    chk("zc_complete_now", {31'd0, bus.xfer_complete}, 32'd1);
    step();
    run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 0, 99, 0, 0);

    // randomized transfers
    for (int it = 0; it < 12; it++) begin
      m      = 1'($urandom_range(0, 1));
      cnt    = $urandom_range(1, 4);
      nblk   = m ? cnt : 1;
      crc_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nblk - 1) : nblk;
      run_xfer(1'($urandom_range(0, 1)), m, 1'b1, 1'($urandom_range(0, 1)),
               cnt, crc_at, $urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dat_xfer_sequencer.md
# dat_xfer_sequencer

Sequencer for the SD host DAT datapath: converts a data-command launch into a sequence of per-block transfers. It gates the datapath's `enable_trans` per block, waits on FIFO readiness and card busy, and counts blocks. It also requests an auto-CMD12 and reports completion, CRC and timeout events to the register/interrupt logic. It sits between the register block (transfer mode, block count, timeout) and the DAT communication datapath.

## Interface
- `BLK_CNT_W`, 16, width of block count and `blocks_left`
- `TMO_W`, 16, width of data-timeout counter and limit
- `clk` in 1: single clock; all logic is posedge `clk`
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle launch pulse; sampled only in IDLE
- `sw_reset` in 1: synchronous abort (software reset register bit)
- `dir` in 1: 1 = read (card→host), 0 = write; sampled at `start`
- `multi_blk` in 1: multiple-block mode; sampled at `start`
- `blk_cnt_en` in 1: block-count enable; sampled at `start`
- `auto_cmd12` in 1: auto CMD12 enable; sampled at `start`
- `blk_cnt` in BLK_CNT_W: block count; sampled at `start`
- `tmo_limit` in TMO_W: data timeout in `clk` cycles; 0 disables the timeout
- `fifo_ready` in 1: write = FIFO holds ≥1 block; read = FIFO has room for 1 block
- `blk_done` in 1: datapath one-cycle pulse, block finished
- `crc_err` in 1: valid with `blk_done`; CRC/status failure
- `dat_busy` in 1: card holding DAT0 low (write busy)
- `cmd12_ack` in 1: command path accepted CMD12
- `enable_trans` out 1: datapath enable, held high for one block
- `blk_dir` out 1: latched `dir`
- `active` out 1: high in every state except IDLE
- `cmd12_req` out 1: level, held until `cmd12_ack`
- `xfer_complete` out 1: one-cycle pulse
- `crc_err_irq` out 1: one-cycle pulse
- `tmo_err_irq` out 1: one-cycle pulse
- `blocks_left` out BLK_CNT_W: remaining block count

## Operation
- States: IDLE, FIFO_WAIT, XFER, BUSY_WAIT, NEXT, CMD12, DONE.
- On `start` in IDLE:
  - Latch the mode inputs.
  - Load the remaining count: `blk_cnt` if `multi_blk` and `blk_cnt_en`; 1 if not `multi_blk`.
  - Infinite mode (`multi_blk` and not `blk_cnt_en`): count is not loaded or decremented.
- Effective count 0 (`multi_blk`, `blk_cnt_en`, `blk_cnt`=0): IDLE→DONE directly. No block transfer, no CMD12.
- All other starts go IDLE→FIFO_WAIT.
- FIFO_WAIT: stay until `fifo_ready`=1, then →XFER.
- XFER: `enable_trans`=1.
  - `blk_done` with `crc_err`=1: pulse `crc_err_irq`, then go to the abort target.
  - Abort target: CMD12 if `multi_blk` and `auto_cmd12`, else IDLE. No `xfer_complete` on abort.
  - `blk_done` with `crc_err`=0, write: →BUSY_WAIT.
  - `blk_done` with `crc_err`=0, read: →NEXT.
- BUSY_WAIT: stay until `dat_busy`=0, then →NEXT.
- NEXT:
  - Decrement `blocks_left`, except in infinite mode.
  - If the pre-decrement value was 1: →CMD12 if `multi_blk` and `auto_cmd12`, else →DONE.
  - Otherwise →FIFO_WAIT.
  - Infinite mode always returns →FIFO_WAIT; it ends only on error or `sw_reset`.
- CMD12: `cmd12_req`=1 until `cmd12_ack`.
  - After a normal finish: →DONE.
  - After a CRC abort: →IDLE.
- DONE: `xfer_complete`=1 for one cycle, then →IDLE.
- Timeout counter:
  - Cleared on entry to XFER and on entry to BUSY_WAIT.
  - Increments every cycle in those states.
  - When it equals a nonzero `tmo_limit`: pulse `tmo_err_irq`, →IDLE. No CMD12, no `xfer_complete`.
  - A `blk_done` in that same cycle is ignored.
- `sw_reset`=1 in any state, highest priority: next state IDLE, counters cleared, all outputs 0, no pulses.
- `start` outside IDLE is ignored. `blk_done` outside XFER is ignored.

## Timing
- Async reset (`reset_n`=0): state IDLE, every output 0, `blocks_left`=0, timeout counter 0.
- All outputs are registered and decoded from state; none is combinational from inputs.
- `start` at cycle N: `active`=1 at N+1.
- `fifo_ready` sampled high at cycle M in FIFO_WAIT: `enable_trans`=1 from M+1.
- `blk_done` at cycle K: `enable_trans`=0 at K+1.
- Read block: NEXT at K+1; next FIFO_WAIT or finish at K+2.
- Last block, no CMD12: DONE at K+2, `xfer_complete` high at K+2, `active`=0 at K+3.
- `cmd12_ack` at cycle C: `cmd12_req`=0 at C+1, DONE at C+1.
- `blocks_left` updates on the cycle after NEXT.
- Timeout: `tmo_limit`=L, state entered at cycle E. Counter reaches L at E+L, so `tmo_err_irq`=1 at E+L+1 and `active`=0 from E+L+1.

## Test plan
- Single-block read (`multi_blk`=0, `fifo_ready`=1, `blk_done` 10 cycles after `enable_trans`) -> one `enable_trans` window; `xfer_complete` 2 cycles after `blk_done`; `cmd12_req` never asserted.
- Multi-block write, `blk_cnt`=3, `auto_cmd12`=1, `dat_busy` high 5 cycles after each block -> 3 `enable_trans` windows; `blocks_left` steps 3→2→1→0; `cmd12_req` until `cmd12_ack`, then `xfer_complete`.
- `fifo_ready` held low 20 cycles before block 2 of 2 -> `enable_trans` stays low 20 cycles; no timeout with `tmo_limit`=8, since FIFO_WAIT is not timed.
- `crc_err` on block 2 of 4, `auto_cmd12`=1 -> `crc_err_irq` pulse; `cmd12_req`; return to IDLE with no `xfer_complete`; `blocks_left`=3.
- `tmo_limit`=16 and no `blk_done` -> `tmo_err_irq` exactly 17 cycles after XFER entry; IDLE; `enable_trans`=0.
- `sw_reset` mid-BUSY_WAIT, plus `blk_cnt_en`=1 with `blk_cnt`=0 -> immediate IDLE with all outputs 0; zero-count start gives `xfer_complete` with no `enable_trans`.
